// File: rtl/fpr_cdb_arbiter.sv
// FPR common data bus arbiter.
// Shares one CDB between round-robin reservation-station requesters (one-cycle
// grant-to-broadcast) and round-robin fixed-latency pipelined units that book
// their landing slot PIPE_LAT cycles ahead in a reservation calendar.
module fpr_cdb_arbiter #(
    parameter int N_RS      = 3,
    parameter int N_PIPE    = 2,
    parameter int PIPE_LAT  = 3,   // legal range 2..15
    parameter int ROB_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_RS-1:0]                     rs_valid,
    output logic [N_RS-1:0]                     rs_ready,
    input  logic [N_RS-1:0][ROB_WIDTH-1:0]      rs_tag,
    input  logic [N_RS-1:0][31:0]               rs_result,
    input  logic [N_PIPE-1:0]                   pipe_start_req,
    output logic [N_PIPE-1:0]                   pipe_start_ack,
    input  logic [N_PIPE-1:0][ROB_WIDTH-1:0]    pipe_tag,
    input  logic [N_PIPE-1:0][31:0]             pipe_result,
    output logic                                cdb_valid,
    output logic [ROB_WIDTH-1:0]                cdb_tag,
    output logic [31:0]                         cdb_data
);

    localparam int RS_IW   = (N_RS   > 1) ? $clog2(N_RS)   : 1;
    localparam int PIPE_IW = (N_PIPE > 1) ? $clog2(N_PIPE) : 1;
    localparam int OWN_IW  = (RS_IW > PIPE_IW) ? RS_IW : PIPE_IW;
    // The slot for now+PIPE_LAT is written by this cycle's ack directly into
    // the shifted calendar, so only slots now+1 .. now+PIPE_LAT-1 are stored.
    localparam int CAL_N   = PIPE_LAT - 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RS   = 2'd1,
        OWN_PIPE = 2'd2
    } own_kind_e;

    typedef struct packed {
        logic               busy;
        logic [PIPE_IW-1:0] idx;
    } slot_t;

    slot_t [CAL_N-1:0]    cal_q, cal_d;
    logic  [RS_IW-1:0]    rs_ptr_q, rs_ptr_d;
    logic  [PIPE_IW-1:0]  pipe_ptr_q, pipe_ptr_d;
    own_kind_e            own_kind_q, own_kind_d;
    logic  [OWN_IW-1:0]   own_idx_q, own_idx_d;
    logic  [ROB_WIDTH-1:0] own_tag_q, own_tag_d;
    logic                 reset_q;
    logic                 blocked;
    logic                 rs_hit, pipe_hit;
    logic  [RS_IW-1:0]    rs_win;
    logic  [PIPE_IW-1:0]  pipe_win;

    function automatic logic [RS_IW-1:0] rs_wrap(input int v);
        return RS_IW'(v % N_RS);
    endfunction

    function automatic logic [PIPE_IW-1:0] pipe_wrap(input int v);
        return PIPE_IW'(v % N_PIPE);
    endfunction

    // No grants or acks while in reset or in the first cycle after it.
    assign blocked = reset | reset_q;

    // Pipe start arbitration: round robin, never blocked by RS traffic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pipe_hit       = 1'b0;
        pipe_win       = '0;
        pipe_start_ack = '0;
        for (int off = 0; off < N_PIPE; off++) begin
            if (!pipe_hit && pipe_start_req[pipe_wrap(int'(pipe_ptr_q) + off)]) begin
                pipe_hit = 1'b1;
                pipe_win = pipe_wrap(int'(pipe_ptr_q) + off);
            end
        end
        if (blocked) pipe_hit = 1'b0;
        if (pipe_hit) pipe_start_ack[pipe_win] = 1'b1;
        pipe_ptr_d = pipe_hit ? pipe_wrap(int'(pipe_win) + 1) : pipe_ptr_q;
    end

    // RS arbitration: round robin, only into a free next-cycle slot.
    always_comb begin
        rs_hit   = 1'b0;
        rs_win   = '0;
        rs_ready = '0;
        for (int off = 0; off < N_RS; off++) begin
            if (!rs_hit && rs_valid[rs_wrap(int'(rs_ptr_q) + off)]) begin
                rs_hit = 1'b1;
                rs_win = rs_wrap(int'(rs_ptr_q) + off);
            end
        end
        if (blocked || cal_q[0].busy) rs_hit = 1'b0;
        if (rs_hit) rs_ready[rs_win] = 1'b1;
        rs_ptr_d = rs_hit ? rs_wrap(int'(rs_win) + 1) : rs_ptr_q;
    end

    // Calendar shift plus booking of this cycle's pipe ack.
    always_comb begin
        cal_d = '0;
        for (int k = 0; k < CAL_N - 1; k++) cal_d[k] = cal_q[k+1];
        if (pipe_hit) cal_d[CAL_N-1] = slot_t'{busy: 1'b1, idx: pipe_win};
    end

    // Next bus owner: a booked pipe slot wins, else the granted RS, else idle.
    always_comb begin
        own_kind_d = OWN_NONE;
        own_idx_d  = '0;
        own_tag_d  = '0;
        if (cal_q[0].busy) begin
            own_kind_d = OWN_PIPE;
            own_idx_d  = OWN_IW'(cal_q[0].idx);
        end else if (rs_hit) begin
            own_kind_d = OWN_RS;
            own_idx_d  = OWN_IW'(rs_win);
            own_tag_d  = rs_tag[rs_win];
        end
    end

    // State registers with synchronous reset; reset drops all reservations.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        reset_q <= reset;
        if (reset) begin
            cal_q      <= '0;
            rs_ptr_q   <= '0;
            pipe_ptr_q <= '0;
            own_kind_q <= OWN_NONE;
            own_idx_q  <= '0;
            own_tag_q  <= '0;
        end else begin
            cal_q      <= cal_d;
            rs_ptr_q   <= rs_ptr_d;
            pipe_ptr_q <= pipe_ptr_d;
            own_kind_q <= own_kind_d;
            own_idx_q  <= own_idx_d;
            own_tag_q  <= own_tag_d;
        end
    end

    // CDB broadcast decoded from the owner register.
    always_comb begin
        cdb_valid = 1'b0;
        cdb_tag   = 'x;
        cdb_data  = 'x;
        case (own_kind_q)
            OWN_RS: begin
                cdb_valid = !reset;
                cdb_tag   = own_tag_q;
                cdb_data  = rs_result[RS_IW'(own_idx_q)];
            end
            OWN_PIPE: begin
                cdb_valid = !reset;
                cdb_tag   = pipe_tag[PIPE_IW'(own_idx_q)];
                cdb_data  = pipe_result[PIPE_IW'(own_idx_q)];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: directed scenarios with literal expectations plus
// an absolute-time bus-schedule model compared against the DUT every cycle.
module tb_fpr_cdb_arbiter;

    localparam int N_RS      = 3;
    localparam int N_PIPE    = 2;
    localparam int PIPE_LAT  = 3;
    localparam int ROB_WIDTH = 6;
    localparam int SCHED     = 512;

    logic                             clk = 1'b0;
    logic                             reset;
    logic [N_RS-1:0]                  rs_valid;
    logic [N_RS-1:0]                  rs_ready;
    logic [N_RS-1:0][ROB_WIDTH-1:0]   rs_tag;
    logic [N_RS-1:0][31:0]            rs_result;
    logic [N_PIPE-1:0]                pipe_start_req;
    logic [N_PIPE-1:0]                pipe_start_ack;
    logic [N_PIPE-1:0][ROB_WIDTH-1:0] pipe_tag;
    logic [N_PIPE-1:0][31:0]          pipe_result;
    logic                             cdb_valid;
    logic [ROB_WIDTH-1:0]             cdb_tag;
    logic [31:0]                      cdb_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    fpr_cdb_arbiter #(
        .N_RS(N_RS), .N_PIPE(N_PIPE), .PIPE_LAT(PIPE_LAT), .ROB_WIDTH(ROB_WIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_tag(rs_tag), .rs_result(rs_result),
        .pipe_start_req(pipe_start_req), .pipe_start_ack(pipe_start_ack),
        .pipe_tag(pipe_tag), .pipe_result(pipe_result),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus in each absolute cycle (0 idle, 1 RS, 2 pipe).
    int                   sk [SCHED];
    int                   si [SCHED];
    logic [ROB_WIDTH-1:0] st [SCHED];
    int                   m_rs_ptr   = 0;
    int                   m_pipe_ptr = 0;
    bit                   m_prev_rst = 1'b0;
    int                   m_c, m_rs_i, m_pipe_j;
    bit                   m_blk;
    logic [N_RS-1:0]      m_ready;
    logic [N_PIPE-1:0]    m_ack;
    logic                 m_valid;
    logic [ROB_WIDTH-1:0] m_tag;
    logic [31:0]          m_data;

    initial begin
        for (int k = 0; k < SCHED; k++) begin
            sk[k] = 0;
            si[k] = 0;
            st[k] = '0;
        end
        forever begin
            @(negedge clk);
            m_c = cyc;
            if (m_c + PIPE_LAT < SCHED) begin
                m_valid = 1'b0;
                m_tag   = '0;
                m_data  = '0;
                if (!reset && sk[m_c] == 1) begin
                    m_valid = 1'b1;
                    m_tag   = st[m_c];
                    m_data  = rs_result[si[m_c]];
                end else if (!reset && sk[m_c] == 2) begin
                    m_valid = 1'b1;
                    m_tag   = pipe_tag[si[m_c]];
                    m_data  = pipe_result[si[m_c]];
                end
                m_blk    = reset || m_prev_rst;
                m_pipe_j = -1;
                m_rs_i   = -1;
                if (!m_blk) begin
                    for (int off = 0; off < N_PIPE; off++)
                        if (m_pipe_j < 0 && pipe_start_req[(m_pipe_ptr + off) % N_PIPE])
                            m_pipe_j = (m_pipe_ptr + off) % N_PIPE;
                    if (sk[m_c+1] == 0)
                        for (int off = 0; off < N_RS; off++)
                            if (m_rs_i < 0 && rs_valid[(m_rs_ptr + off) % N_RS])
                                m_rs_i = (m_rs_ptr + off) % N_RS;
                end
                m_ack   = '0;
                m_ready = '0;
                if (m_pipe_j >= 0) m_ack[m_pipe_j] = 1'b1;
                if (m_rs_i >= 0) m_ready[m_rs_i] = 1'b1;

                check("model_ack", 64'(pipe_start_ack), 64'(m_ack));
                check("model_ready", 64'(rs_ready), 64'(m_ready));
                check("model_cdb_valid", 64'(cdb_valid), 64'(m_valid));
                if (m_valid) begin
                    check("model_cdb_tag", 64'(cdb_tag), 64'(m_tag));
                    check("model_cdb_data", 64'(cdb_data), 64'(m_data));
                end

                if (reset) begin
                    for (int k = m_c + 1; k < SCHED; k++) sk[k] = 0;
                    m_rs_ptr   = 0;
                    m_pipe_ptr = 0;
                end else begin
                    if (m_pipe_j >= 0) begin
                        sk[m_c+PIPE_LAT] = 2;
                        si[m_c+PIPE_LAT] = m_pipe_j;
                        m_pipe_ptr = (m_pipe_j + 1) % N_PIPE;
                    end
                    if (m_rs_i >= 0) begin
                        sk[m_c+1] = 1;
                        si[m_c+1] = m_rs_i;
                        st[m_c+1] = rs_tag[m_rs_i];
                        m_rs_ptr = (m_rs_i + 1) % N_RS;
                    end
                end
                m_prev_rst = reset;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Directed scenarios with literal expectations.
    initial begin
        reset          = 1'b1;
        rs_valid       = '1;
        pipe_start_req = '1;
        rs_tag         = '0;
        rs_result      = '0;
        pipe_tag       = '0;
        pipe_result    = '0;
        repeat (2) tick();
        check("reset_ready", 64'(rs_ready), 64'd0);
        check("reset_ack", 64'(pipe_start_ack), 64'd0);
        check("reset_valid", 64'(cdb_valid), 64'd0);
        tick();

        // First cycle after reset: still quiet even with requests pending.
        reset          = 1'b0;
        pipe_start_req = '0;
        rs_valid       = '1;
        for (int i = 0; i < N_RS; i++) begin
            rs_tag[i]    = ROB_WIDTH'(10 + i);
            rs_result[i] = 32'hA000_0000 + 32'(i);
        end
        #1;
        check("post_reset_ready", 64'(rs_ready), 64'd0);
        check("post_reset_valid", 64'(cdb_valid), 64'd0);
        tick();

        // Round robin over all RS for six cycles.
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 64'(rs_ready), 64'(1 << (k % 3)));
            if (k > 0) begin
                check("rr_valid", 64'(cdb_valid), 64'd1);
                check("rr_tag", 64'(cdb_tag), 64'(10 + (k - 1) % 3));
                check("rr_data", 64'(cdb_data), 64'(32'hA000_0000 + 32'((k - 1) % 3)));
            end
            tick();
        end
        rs_valid = '0;
        #1;
        check("rr_last_valid", 64'(cdb_valid), 64'd1);
        check("rr_last_tag", 64'(cdb_tag), 64'd12);
        tick();

        // Single RS request.
        rs_valid  = 3'b010;
        rs_tag[1] = 6'd5;
        #1;
        check("single_ready", 64'(rs_ready), 64'b010);
        tick();
        rs_valid     = '0;
        rs_result[1] = 32'h3f80_0000;
        #1;
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag), 64'd5);
        check("single_data", 64'(cdb_data), 64'h3f80_0000);
        tick();
        #1;
        check("single_idle", 64'(cdb_valid), 64'd0);
        tick();

        // Pipe reservation blocks the RS slot PIPE_LAT cycles later.
        rs_valid       = 3'b001;
        pipe_start_req = 2'b01;
        pipe_tag[0]    = 6'd9;
        pipe_result[0] = 32'h4000_0000;
        #1;
        check("pr_ack", 64'(pipe_start_ack), 64'b01);
        check("pr_ready_t0", 64'(rs_ready), 64'b001);
        tick();
        pipe_start_req = '0;
        #1;
        check("pr_ready_t1", 64'(rs_ready), 64'b001);
        tick();
        #1;
        check("pr_ready_t2", 64'(rs_ready), 64'b000);
        tick();
        #1;
        check("pr_valid_t3", 64'(cdb_valid), 64'd1);
        check("pr_tag_t3", 64'(cdb_tag), 64'd9);
        check("pr_data_t3", 64'(cdb_data), 64'h4000_0000);
        tick();
        rs_valid = '0;
        repeat (2) tick();

        // Reset mid-flight discards the booked pipe slot.
        pipe_start_req = 2'b10;
        pipe_tag[1]    = 6'd40;
        #1;
        check("mf_ack", 64'(pipe_start_ack), 64'b10);
        tick();
        pipe_start_req = '0;
        reset          = 1'b1;
        #1;
        check("mf_valid_t1", 64'(cdb_valid), 64'd0);
        tick();
        reset    = 1'b0;
        rs_valid = '1;
        #1;
        check("mf_valid_t2", 64'(cdb_valid), 64'd0);
        check("mf_ready_t2", 64'(rs_ready), 64'd0);
        tick();
        #1;
        check("mf_valid_t3", 64'(cdb_valid), 64'd0);
        check("mf_ready_t3", 64'(rs_ready), 64'b001);
        tick();
        rs_valid = '0;
        #1;
        check("mf_valid_t4", 64'(cdb_valid), 64'd1);
        check("mf_tag_t4", 64'(cdb_tag), 64'd10);
        tick();

        // Pipe contention with all RS requesting.
        pipe_start_req = 2'b11;
        rs_valid       = '1;
        pipe_tag[0]    = 6'd20;
        pipe_tag[1]    = 6'd21;
        pipe_result[0] = 32'hC000_0000;
        pipe_result[1] = 32'hC100_0000;
        for (int t = 0; t < 7; t++) begin
            if (t == 4) pipe_start_req = '0;
            #1;
            check("ct_ack", 64'(pipe_start_ack), (t < 4) ? ((t % 2 == 0) ? 64'b01 : 64'b10) : 64'd0);
            check("ct_ready", 64'(rs_ready),
                  (t == 0) ? 64'b010 : (t == 1) ? 64'b100 : (t == 6) ? 64'b001 : 64'd0);
            if (t >= 3) begin
                check("ct_valid", 64'(cdb_valid), 64'd1);
                check("ct_tag", 64'(cdb_tag), (t % 2 == 1) ? 64'd20 : 64'd21);
                check("ct_data", 64'(cdb_data), (t % 2 == 1) ? 64'hC000_0000 : 64'hC100_0000);
            end
            tick();
        end
        rs_valid = '0;
        #1;
        check("ct_rs_tag", 64'(cdb_tag), 64'd10);
        tick();

        // Back-to-back mix: RS at t+1, RS at t+2, pipe at t+3.
        pipe_start_req = 2'b01;
        rs_valid       = 3'b001;
        rs_tag[0]      = 6'd30;
        pipe_tag[0]    = 6'd50;
        pipe_result[0] = 32'h1234_5678;
        #1;
        check("mx_ack", 64'(pipe_start_ack), 64'b01);
        check("mx_ready_t0", 64'(rs_ready), 64'b001);
        tick();
        pipe_start_req = '0;
        rs_tag[0]      = 6'd31;
        rs_result[0]   = 32'hDEAD_0001;
        #1;
        check("mx_ready_t1", 64'(rs_ready), 64'b001);
        check("mx_tag_t1", 64'(cdb_tag), 64'd30);
        check("mx_data_t1", 64'(cdb_data), 64'hDEAD_0001);
        tick();
        rs_valid     = '0;
        rs_result[0] = 32'hDEAD_0002;
        #1;
        check("mx_tag_t2", 64'(cdb_tag), 64'd31);
        check("mx_data_t2", 64'(cdb_data), 64'hDEAD_0002);
        tick();
        #1;
        check("mx_valid_t3", 64'(cdb_valid), 64'd1);
        check("mx_tag_t3", 64'(cdb_tag), 64'd50);
        check("mx_data_t3", 64'(cdb_data), 64'h1234_5678);
        tick();
        #1;
        check("mx_idle_t4", 64'(cdb_valid), 64'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
